// File: rtl/add_mop_seq.sv
// rtl/add_mop_seq.sv - serial multi-operand adder: accumulates up to depth operands, returns sum/count/overflow
module add_mop_seq #(
  parameter int BW    = 8,
  parameter int depth = 4,
  parameter int CW    = $clog2(depth + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [BW-1:0] in_data_i,
  input  logic          in_last_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [BW-1:0] out_sum_o,
  output logic [CW-1:0] out_cnt_o,
  output logic          out_ovf_o
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  localparam logic [CW-1:0] DEPTH_C = CW'(depth);

  state_t        state, state_nxt;
  logic [BW-1:0] acc;
  logic [CW-1:0] cnt;
  logic          ovf;
  logic          accept;
  logic [BW:0]   sum_w;
  logic [CW-1:0] cnt_inc;

  assign accept  = in_valid_i && in_ready_o;
  assign sum_w   = {1'b0, acc} + {1'b0, in_data_i};
  assign cnt_inc = cnt + CW'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        if (state == IDLE) begin
          acc <= in_data_i;
          cnt <= CW'(1);
          ovf <= 1'b0;
        end else begin
          acc <= sum_w[BW-1:0];
          cnt <= cnt_inc;
          ovf <= ovf | sum_w[BW];
        end
      end
    end
  end

  // Handshake flags are pure functions of state so neither port sees a combinational path from the other.
  always_comb begin
    state_nxt   = state;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (state)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          state_nxt = (in_last_i || depth == 1) ? DONE : ACC;
        end
      end
      ACC: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          state_nxt = (in_last_i || cnt_inc == DEPTH_C) ? DONE : ACC;
        end
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign out_sum_o = acc;
  assign out_cnt_o = cnt;
  assign out_ovf_o = ovf;

endmodule

// File: tb/tb_add_mop_seq.sv
// tb/tb_add_mop_seq.sv - scoreboard bench for add_mop_seq (BW=8/depth=4 plus BW=4/depth=1 corner)
module tb_add_mop_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_sum;
  logic [2:0] out_cnt;
  logic       out_ovf;

  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [3:0] s_data = 4'h0;
  logic       s_ovalid;
  logic       s_oready = 1'b1;
  logic [3:0] s_sum;
  logic [0:0] s_cnt;
  logic       s_ovf;

  always #5 clk = ~clk;

  add_mop_seq #(.BW(8), .depth(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .in_last_i(in_last),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_sum_o(out_sum), .out_cnt_o(out_cnt), .out_ovf_o(out_ovf)
  );

  add_mop_seq #(.BW(4), .depth(1)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(s_valid), .in_ready_o(s_ready), .in_data_i(s_data), .in_last_i(1'b0),
    .out_valid_o(s_ovalid), .out_ready_i(s_oready),
    .out_sum_o(s_sum), .out_cnt_o(s_cnt), .out_ovf_o(s_ovf)
  );

  typedef struct packed {
    logic [7:0] s;
    logic [2:0] c;
    logic       o;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every result transfer is compared against the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sum", int'(out_sum), int'(e.s));
        chk("cnt", int'(out_cnt), int'(e.c));
        chk("ovf", int'(out_ovf), int'(e.o));
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 1, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic push(input logic [7:0] s, input logic [2:0] c, input logic o);
    exp_t e;
    e.s = s; e.c = c; e.o = o;
    exp_q.push_back(e);
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_sum", int'(out_sum), 0);
    chk("rst_cnt", int'(out_cnt), 0);
    chk("rst_ovf", int'(out_ovf), 0);
    @(posedge clk); #1;

    // 1+2+3+4 with last on the 4th; valid the cycle after the closing accept
    push(8'd10, 3'd4, 1'b0);
    send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b0); send(8'd4, 1'b1);
    chk("latency_valid", int'(out_valid), 1);
    chk("done_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    chk("idle_after_xfer", int'(in_ready), 1);
    chk("idle_valid_low", int'(out_valid), 0);

    // wrap and sticky overflow, closed by depth without last
    push(8'h00, 3'd4, 1'b1);
    send(8'hFF, 1'b0); send(8'h01, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
    push(8'hA0, 3'd4, 1'b0);
    send(8'h10, 1'b0); send(8'h20, 1'b0); send(8'h30, 1'b0); send(8'h40, 1'b0);

    // early last with bubbles, then single-beat frame
    push(8'd12, 3'd2, 1'b0);
    send(8'd5, 1'b0);
    repeat (2) @(posedge clk); #1;
    send(8'd7, 1'b1);
    push(8'd9, 3'd1, 1'b0);
    send(8'd9, 1'b1);

    // backpressure: result held, offered beat refused
    @(posedge clk); #1;
    out_ready = 1'b0;
    push(8'd10, 3'd4, 1'b0);
    send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b0); send(8'd4, 1'b1);
    in_valid = 1'b1; in_data = 8'h55; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_sum", int'(out_sum), 10);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_valid", int'(out_valid), 0);
    chk("bp_idle_ready", int'(in_ready), 1);

    // reset mid-frame discards partial sum
    send(8'h11, 1'b0); send(8'h22, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_ready", int'(in_ready), 1);
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_sum", int'(out_sum), 0);
    chk("mid_rst_cnt", int'(out_cnt), 0);
    push(8'd4, 3'd4, 1'b0);
    send(8'd1, 1'b0); send(8'd1, 1'b0); send(8'd1, 1'b0); send(8'd1, 1'b0);

    // reset while a result is pending drops it
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(8'd5, 1'b1);
    chk("pend_valid", int'(out_valid), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("pend_dropped", int'(out_valid), 0);
    out_ready = 1'b1;

    // depth=1 corner: one beat per result, accepted every second cycle
    s_valid = 1'b1; s_data = 4'hF;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("d1_ready", int'(s_ready), (i % 2 == 0) ? 1 : 0);
      chk("d1_valid", int'(s_ovalid), (i % 2 == 1) ? 1 : 0);
      if (s_ovalid) begin
        chk("d1_sum", int'(s_sum), 15);
        chk("d1_cnt", int'(s_cnt), 1);
        chk("d1_ovf", int'(s_ovf), 0);
      end
    end
    s_valid = 1'b0;

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
